ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares one single-port data RAM slave between two masters: m0 is instruction fetch, m1 is load/store.
- Both masters and the RAM slave use the same req/rsp valid/ready handshake.
- Round-robin arbitration with at most one outstanding transaction.
- Sits between the core bus masters and the RAM slave's req/rsp ports.

Parameters:
AW, 32, address width
DW, 32, data width
MW, 4, byte-select width (DW/8)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m{0,1}_addr_i  in  AW  master address
m{0,1}_data_i  in  DW  master write data
m{0,1}_sel_i  in  MW  master byte selects
m{0,1}_we_i  in  1  master write enable
m{0,1}_req_valid_i  in  1  master request valid
m{0,1}_req_ready_o  out  1  request accepted by arbiter/slave
m{0,1}_rsp_valid_o  out  1  response valid to master
m{0,1}_rsp_ready_i  in  1  master accepts response
m{0,1}_data_o  out  DW  read data (broadcast of s_data_i)
s_addr_o / s_data_o / s_sel_o / s_we_o  out  AW/DW/MW/1  muxed request to RAM slave
s_req_valid_o  out  1  request valid to slave
s_req_ready_i  in  1  slave accepts request
s_rsp_valid_i  in  1  slave response valid
s_rsp_ready_o  out  1  response ready to slave
s_data_i  in  DW  slave read data
owner_o  out  1  current/last granted master
busy_o  out  1  high in REQ or RSP state

Behaviour:
- Reset: one clock, synchronous, active-high (rst), reset on rising edge of clk.
- Reset values: state=IDLE, rr_ptr=0, owner=0. While rst=1 every *_valid_o and *_ready_o output is 0.
- States:
  - IDLE: no grant held.
  - REQ: grant held, waiting for s_req_ready_i.
  - RSP: request accepted, waiting for the response handshake.
- IDLE grant (combinational):
  - Only one master valid: that master is granted.
  - Both valid: master rr_ptr is granted.
  - Neither valid: no grant; s_req_valid_o=0.
- Granted master's addr/data/sel/we drive s_*_o. s_req_valid_o=1.
- Granted master's req_ready_o = s_req_ready_i. The other master's req_ready_o=0.
- From IDLE with a grant:
  - s_req_ready_i=1: go to RSP and register owner.
  - s_req_ready_i=0: go to REQ and register owner, so the grant stays stable even if the other master raises valid.
- REQ:
  - Mux and valid come from the registered owner.
  - Leave for RSP on s_req_ready_i=1.
  - Owner dropping valid is a protocol violation; the arbiter holds REQ and keeps s_req_valid_o = owner's valid.
- RSP:
  - s_req_valid_o=0. Both m*_req_ready_o=0.
  - owner rsp_valid_o = s_rsp_valid_i; other master rsp_valid_o=0.
  - s_rsp_ready_o = owner's rsp_ready_i.
  - On s_rsp_valid_i & s_rsp_ready_o: go to IDLE and set rr_ptr = ~owner.
- rr_ptr updates only on response completion. A lone requester gets back-to-back service.
- m*_data_o = s_data_i unconditionally. Masters qualify data with rsp_valid.
- Throughput: at most one transaction per 2 cycles (request cycle plus response-handshake cycle). A new request is never accepted in the same cycle as a response handshake.
- No combinational path from any m*_req_valid_i to m*_rsp_valid_o.
- s_rsp_valid_i in IDLE or REQ (spurious): ignored, s_rsp_ready_o=0.
- Reset mid-operation (REQ or RSP): return to IDLE and drop the in-flight transaction. No response is delivered afterwards.
- owner_o = registered owner in REQ/RSP, else the IDLE combinational grant (0 when neither master is valid).
- busy_o = (state != IDLE).

Test Plan:
- Single read: m1 issues addr=0x100, we=0, slave ready immediately, response after 1 cycle with s_data_i=0xDEADBEEF -> m1_req_ready_o=1 in cycle 0, m1_rsp_valid_o=1 in cycle 1, m1_data_o=0xDEADBEEF, m0 sees no valid/ready.
- Contention after reset: m0 and m1 valid in the same cycle -> m0 granted first (rr_ptr=0). After m0's response, m1 granted. Grant order 0,1,0,1 over 4 transactions with both continuously valid.
- Ready backpressure: m1 granted alone, s_req_ready_i=0 for 3 cycles, m0 raises valid in cycle 1 -> s_addr_o stays m1_addr_i, owner_o=1 throughout, m1 accepted in cycle 3.
- Response backpressure: response with m0_rsp_ready_i=0 for 2 cycles -> s_rsp_ready_o=0, state holds RSP, m1 request not accepted until 1 cycle after the handshake.
- Write: m0 addr=0x40, data=0x12345678, sel=4'b0011, we=1 -> s_*_o match exactly, s_we_o=1, response routed to m0 only.
- Reset in RSP: assert rst for 1 cycle while waiting for the response -> busy_o=0 next cycle, all valid/ready outputs 0 during reset, later s_rsp_valid_i pulse not forwarded, rr_ptr=0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port RAM slave.
// At most one transaction is in flight; the grant is frozen once the request is presented.
module ram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_data_i,
  input  logic [MW-1:0] m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_req_valid_i,
  output logic          m0_req_ready_o,
  output logic          m0_rsp_valid_o,
  input  logic          m0_rsp_ready_i,
  output logic [DW-1:0] m0_data_o,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_data_i,
  input  logic [MW-1:0] m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_req_valid_i,
  output logic          m1_req_ready_o,
  output logic          m1_rsp_valid_o,
  input  logic          m1_rsp_ready_i,
  output logic [DW-1:0] m1_data_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_data_o,
  output logic [MW-1:0] s_sel_o,
  output logic          s_we_o,
  output logic          s_req_valid_o,
  input  logic          s_req_ready_i,
  input  logic          s_rsp_valid_i,
  output logic          s_rsp_ready_o,
  input  logic [DW-1:0] s_data_i,
  output logic          owner_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;

  state_t state_r, state_nxt_s;
  logic   owner_r, owner_nxt_s;
  logic   rr_ptr_r, rr_ptr_nxt_s;
  logic   any_valid_s, grant_s, sel_s, sel_valid_s, sel_rsp_ready_s;

  // Round-robin pick among the masters currently presenting a request.
  always_comb begin
    any_valid_s = m0_req_valid_i | m1_req_valid_i;
    if (m0_req_valid_i && m1_req_valid_i) begin
      grant_s = rr_ptr_r;
    end else if (m1_req_valid_i) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign sel_s           = (state_r == IDLE) ? grant_s : owner_r;
  assign sel_valid_s     = sel_s ? m1_req_valid_i : m0_req_valid_i;
  assign sel_rsp_ready_s = owner_r ? m1_rsp_ready_i : m0_rsp_ready_i;
  assign s_addr_o        = sel_s ? m1_addr_i : m0_addr_i;
  assign s_data_o        = sel_s ? m1_data_i : m0_data_i;
  assign s_sel_o         = sel_s ? m1_sel_i  : m0_sel_i;
  assign s_we_o          = sel_s ? m1_we_i   : m0_we_i;
  assign m0_data_o       = s_data_i;
  assign m1_data_o       = s_data_i;
  assign busy_o          = (state_r != IDLE);

  // Next-state, handshake routing and owner reporting; reset forces every valid/ready low.
  always_comb begin
    state_nxt_s    = state_r;
    owner_nxt_s    = owner_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    s_req_valid_o  = 1'b0;
    s_rsp_ready_o  = 1'b0;
    m0_req_ready_o = 1'b0;
    m1_req_ready_o = 1'b0;
    m0_rsp_valid_o = 1'b0;
    m1_rsp_valid_o = 1'b0;
    owner_o        = owner_r;
    if (rst) begin
      state_nxt_s  = IDLE;
      owner_nxt_s  = 1'b0;
      rr_ptr_nxt_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          owner_o = grant_s;
          if (any_valid_s) begin
            s_req_valid_o  = 1'b1;
            m0_req_ready_o = ~grant_s & s_req_ready_i;
            m1_req_ready_o = grant_s & s_req_ready_i;
            owner_nxt_s    = grant_s;
            state_nxt_s    = s_req_ready_i ? RSP : REQ;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        REQ: begin
          // A master withdrawing its request here is illegal; just keep waiting.
          s_req_valid_o  = sel_valid_s;
          m0_req_ready_o = ~owner_r & s_req_ready_i;
          m1_req_ready_o = owner_r & s_req_ready_i;
          if (sel_valid_s && s_req_ready_i) begin
            state_nxt_s = RSP;
          end else begin
            state_nxt_s = REQ;
          end
        end
        RSP: begin
          m0_rsp_valid_o = ~owner_r & s_rsp_valid_i;
          m1_rsp_valid_o = owner_r & s_rsp_valid_i;
          s_rsp_ready_o  = sel_rsp_ready_s;
          if (s_rsp_valid_i && sel_rsp_ready_s) begin
            state_nxt_s  = IDLE;
            rr_ptr_nxt_s = ~owner_r;
          end else begin
            state_nxt_s = RSP;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      owner_r  <= 1'b0;
      rr_ptr_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      owner_r  <= owner_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Table-driven bench for ram_arbiter with a response scoreboard.
module tb_ram_arbiter;
  logic clk, rst;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, m0_rdata, m1_rdata;
  logic [3:0]  m0_sel, m1_sel;
  logic m0_we, m1_we, m0_req_valid, m1_req_valid, m0_req_ready, m1_req_ready;
  logic m0_rsp_valid, m1_rsp_valid, m0_rsp_ready, m1_rsp_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_sel;
  logic s_we, s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready, owner, busy;

  typedef struct {
    logic        rst, v0, v1, sreq, srsp, r0, r1;
    logic [31:0] sdata;
    logic [7:0]  e_flags;  // {rdy0, rdy1, s_req_valid, rsp_valid0, rsp_valid1, s_rsp_ready, owner, busy}
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[$];
  logic [32:0] rsp_q[$];  // {master, data}
  int checks = 0;
  int errors = 0;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr), .m0_data_i(m0_wdata), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_req_valid_i(m0_req_valid), .m0_req_ready_o(m0_req_ready),
    .m0_rsp_valid_o(m0_rsp_valid), .m0_rsp_ready_i(m0_rsp_ready), .m0_data_o(m0_rdata),
    .m1_addr_i(m1_addr), .m1_data_i(m1_wdata), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_req_valid_i(m1_req_valid), .m1_req_ready_o(m1_req_ready),
    .m1_rsp_valid_o(m1_rsp_valid), .m1_rsp_ready_i(m1_rsp_ready), .m1_data_o(m1_rdata),
    .s_addr_o(s_addr), .s_data_o(s_wdata), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_req_valid_o(s_req_valid), .s_req_ready_i(s_req_ready),
    .s_rsp_valid_i(s_rsp_valid), .s_rsp_ready_o(s_rsp_ready), .s_data_i(s_rdata),
    .owner_o(owner), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, v0, v1, sreq, srsp, r0, r1,
                              input logic [31:0] sd, input logic [7:0] fl, input logic [31:0] ad);
    vec_t v;
    v.rst = r; v.v0 = v0; v.v1 = v1; v.sreq = sreq; v.srsp = srsp;
    v.r0 = r0; v.r1 = r1; v.sdata = sd; v.e_flags = fl; v.e_addr = ad;
    return v;
  endfunction

  // Response scoreboard: every delivered response must match the oldest expected one.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      if (m0_rsp_valid === 1'b1 && m0_rsp_ready === 1'b1) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected_m0", 64'd1, 64'd0);
        else chk("rsp_m0", {31'd0, 1'b0, m0_rdata}, {31'd0, rsp_q.pop_front()});
      end
      if (m1_rsp_valid === 1'b1 && m1_rsp_ready === 1'b1) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected_m1", 64'd1, 64'd0);
        else chk("rsp_m1", {31'd0, 1'b1, m1_rdata}, {31'd0, rsp_q.pop_front()});
      end
    end
  end

  task automatic drive(input vec_t v);
    rst = v.rst; m0_req_valid = v.v0; m1_req_valid = v.v1; s_req_ready = v.sreq;
    s_rsp_valid = v.srsp; m0_rsp_ready = v.r0; m1_rsp_ready = v.r1; s_rdata = v.sdata;
  endtask

  initial begin
    logic [7:0] act_flags;
    m0_addr = 32'h0000_0040; m0_wdata = 32'h1234_5678; m0_sel = 4'b0011; m0_we = 1'b1;
    m1_addr = 32'h0000_0100; m1_wdata = 32'hA5A5_A5A5; m1_sel = 4'b1111; m1_we = 1'b0;
    drive(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 32'h0));

    //             rst   v0    v1    sreq  srsp  r0    r1    sdata          flags         addr
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,        8'b0000_0000, 32'h0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        8'b0110_0010, 32'h100));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 8'b0000_1111, 32'h0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        8'b1010_0000, 32'h40));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hCAFE0001, 8'b0001_0101, 32'h0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        8'b0000_0000, 32'h0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        8'b1010_0000, 32'h40));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h11111111, 8'b0001_0101, 32'h0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        8'b0110_0010, 32'h100));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h22222222, 8'b0000_1111, 32'h0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        8'b1010_0000, 32'h40));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h33333333, 8'b0001_0101, 32'h0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        8'b0110_0010, 32'h100));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44444444, 8'b0000_1111, 32'h0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        8'b0010_0010, 32'h100));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        8'b0010_0011, 32'h100));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        8'b0010_0011, 32'h100));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        8'b0110_0011, 32'h100));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h55555555, 8'b0000_1111, 32'h0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        8'b1010_0000, 32'h40));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h66666666, 8'b0001_0001, 32'h0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h66666666, 8'b0001_0001, 32'h0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h66666666, 8'b0001_0101, 32'h0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        8'b0110_0010, 32'h100));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,        8'b0000_0011, 32'h0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hBAD0BAD0, 8'b0000_0000, 32'h0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        8'b0010_0000, 32'h40));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        8'b1000_0001, 32'h0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        8'b1010_0001, 32'h40));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h77777777, 8'b0001_0101, 32'h0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        8'b0000_0000, 32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      if (tbl[i].e_flags[4] && tbl[i].r0) rsp_q.push_back({1'b0, tbl[i].sdata});
      if (tbl[i].e_flags[3] && tbl[i].r1) rsp_q.push_back({1'b1, tbl[i].sdata});
      #3;
      act_flags = {m0_req_ready, m1_req_ready, s_req_valid, m0_rsp_valid,
                   m1_rsp_valid, s_rsp_ready, owner, busy};
      chk($sformatf("vec%0d_flags", i), {56'd0, act_flags}, {56'd0, tbl[i].e_flags});
      if (tbl[i].e_flags[5]) begin
        if (tbl[i].e_flags[1])
          chk($sformatf("vec%0d_smux", i), {s_addr, s_wdata[27:0], s_sel, s_we},
              {tbl[i].e_addr, m1_wdata[27:0], m1_sel, m1_we});
        else
          chk($sformatf("vec%0d_smux", i), {s_addr, s_wdata[27:0], s_sel, s_we},
              {tbl[i].e_addr, m0_wdata[27:0], m0_sel, m0_we});
      end
    end

    // Lone m0 gets back-to-back service even though rr_ptr points at m1.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 8'h00, 32'h0));
      #3;
      chk($sformatf("lone%0d_req", k), {62'd0, m0_req_ready, m1_req_ready}, {62'd0, 2'b10});
      @(negedge clk);
      drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h88880000 + k, 8'h00, 32'h0));
      rsp_q.push_back({1'b0, 32'h88880000 + k});
      #3;
      chk($sformatf("lone%0d_rsp", k), {62'd0, m0_rsp_valid, m1_rsp_valid}, {62'd0, 2'b10});
    end

    @(negedge clk);
    drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 32'h0));
    @(negedge clk);
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
